// File: rtl/matmul_bt_operand_streamer_if.sv
// Operand-pair stream from the transposed-B operand streamer to the MAC datapath.
// The master drives the beat fields and valid; the slave drives ready.
interface matmul_bt_operand_streamer_if #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 8
);
  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              last_k;
  logic [DIM_W-1:0]  out_row;
  logic [DIM_W-1:0]  out_col;

  modport master (
    output valid_out, data_a, data_b, last_k, out_row, out_col,
    input  ready_in
  );

  modport slave (
    input  valid_out, data_a, data_b, last_k, out_row, out_col,
    output ready_in
  );
endinterface

// File: rtl/matmul_bt_operand_streamer.sv
// Streams (A[i][k], B[j][k]) operand pairs in i/j/k dot-product order from two
// synchronous-read memories through a credit-guarded 2-entry output FIFO.
module matmul_bt_operand_streamer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [DIM_W-1:0]             dim_m_i,
  input  logic [DIM_W-1:0]             dim_n_i,
  input  logic [DIM_W-1:0]             dim_k_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         a_rd_en_o,
  output logic                         b_rd_en_o,
  output logic [ADDR_W-1:0]            a_rd_addr_o,
  output logic [ADDR_W-1:0]            b_rd_addr_o,
  input  logic [DATA_W-1:0]            a_rd_data_i,
  input  logic [DATA_W-1:0]            b_rd_data_i,
  matmul_bt_operand_streamer_if.master out_if
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  typedef struct packed {
    logic             last;
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    tag_t              tag;
  } beat_t;

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [DIM_W-1:0]  m_q, n_q, k_q;
  logic [DIM_W-1:0]  i_q, j_q, kk_q;
  logic [ADDR_W-1:0] a_base_q, b_base_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  tag_t              iss_tag_q;
  logic              land_q;
  tag_t              land_tag_q;
  beat_t             slot_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q;

  logic              idle;
  logic [DIM_W-1:0]  cur_m, cur_n, cur_k, cur_i, cur_j, cur_kk;
  logic [ADDR_W-1:0] cur_a_base, cur_b_base;
  logic              dims_zero, k_wrap, j_wrap, is_final;
  beat_t             land_beat, head_beat;
  logic              head_valid, pop, slot_pop, land_store;
  logic [1:0]        cnt_d;
  logic              can_issue, do_issue, drain_empty;

  // In IDLE the first read is issued straight from the incoming dims.
  assign idle       = (state_q == IDLE);
  assign cur_m      = idle ? dim_m_i : m_q;
  assign cur_n      = idle ? dim_n_i : n_q;
  assign cur_k      = idle ? dim_k_i : k_q;
  assign cur_i      = idle ? '0 : i_q;
  assign cur_j      = idle ? '0 : j_q;
  assign cur_kk     = idle ? '0 : kk_q;
  assign cur_a_base = idle ? '0 : a_base_q;
  assign cur_b_base = idle ? '0 : b_base_q;

  assign dims_zero = (dim_m_i == '0) || (dim_n_i == '0) || (dim_k_i == '0);
  assign k_wrap    = (cur_kk == cur_k - DIM_ONE);
  assign j_wrap    = (cur_j == cur_n - DIM_ONE);
  assign is_final  = k_wrap && j_wrap && (cur_i == cur_m - DIM_ONE);

  // Landing read data is forwarded as the head when the FIFO is empty.
  assign land_beat  = '{a: a_rd_data_i, b: b_rd_data_i, tag: land_tag_q};
  assign head_valid = (cnt_q != 2'd0) || land_q;

  always_comb begin
    head_beat = '0;
    if (cnt_q != 2'd0) begin
      head_beat = slot_q[rd_ptr_q];
    end else if (land_q) begin
      head_beat = land_beat;
    end
  end

  assign pop        = head_valid && out_if.ready_in;
  assign slot_pop   = pop && (cnt_q != 2'd0);
  assign land_store = land_q && !(pop && (cnt_q == 2'd0));
  assign cnt_d      = cnt_q + 2'(land_store) - 2'(slot_pop);

  // Stored + landing-next + issuing-next must never exceed the two slots.
  assign can_issue   = (3'(cnt_d) + 3'(rd_en_q)) < 3'd2;
  assign do_issue    = (idle && start_i && !dims_zero) || ((state_q == ISSUE) && can_issue);
  assign drain_empty = (cnt_d == 2'd0) && !rd_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      m_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      kk_q       <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      rd_en_q    <= 1'b0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      iss_tag_q  <= '0;
      land_q     <= 1'b0;
      land_tag_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      done_q     <= 1'b0;
      rd_en_q    <= do_issue;
      land_q     <= rd_en_q;
      land_tag_q <= iss_tag_q;
      cnt_q      <= cnt_d;
      if (land_store) wr_ptr_q <= ~wr_ptr_q;
      if (slot_pop)   rd_ptr_q <= ~rd_ptr_q;

      if (do_issue) begin
        a_addr_q  <= cur_a_base + ADDR_W'(cur_kk);
        b_addr_q  <= cur_b_base + ADDR_W'(cur_kk);
        iss_tag_q <= '{last: k_wrap, row: cur_i, col: cur_j};
        i_q       <= cur_i;
        j_q       <= cur_j;
        a_base_q  <= cur_a_base;
        b_base_q  <= cur_b_base;
        if (k_wrap) begin
          kk_q <= '0;
          if (j_wrap) begin
            j_q      <= '0;
            b_base_q <= '0;
            i_q      <= cur_i + DIM_ONE;
            a_base_q <= cur_a_base + ADDR_W'(cur_k);
          end else begin
            j_q      <= cur_j + DIM_ONE;
            b_base_q <= cur_b_base + ADDR_W'(cur_k);
          end
        end else begin
          kk_q <= cur_kk + DIM_ONE;
        end
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            m_q    <= dim_m_i;
            n_q    <= dim_n_i;
            k_q    <= dim_k_i;
            busy_q <= 1'b1;
            if (dims_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= is_final ? DRAIN : ISSUE;
            end
          end
        end
        ISSUE: begin
          if (do_issue && is_final) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drain_empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) slot_q[s] <= '0;
    end else if (land_store) begin
      slot_q[wr_ptr_q] <= land_beat;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign a_rd_en_o   = rd_en_q;
  assign b_rd_en_o   = rd_en_q;
  assign a_rd_addr_o = a_addr_q;
  assign b_rd_addr_o = b_addr_q;

  assign out_if.valid_out = head_valid;
  assign out_if.data_a    = head_beat.a;
  assign out_if.data_b    = head_beat.b;
  assign out_if.last_k    = head_beat.tag.last;
  assign out_if.out_row   = head_beat.tag.row;
  assign out_if.out_col   = head_beat.tag.col;

endmodule

// File: tb/tb_matmul_bt_operand_streamer.sv
// Runs directed and random-dimension jobs, comparing every beat and read address
// against an i/j/k loop-nest model of the operand order.
module tb_matmul_bt_operand_streamer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 8;
  localparam int BUDGET = 400;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  dim_m = '0, dim_n = '0, dim_k = '0;
  logic              busy, done, a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
  logic [DATA_W-1:0] a_rd_data = '0, b_rd_data = '0;
  logic [DATA_W-1:0] mem_a [256];
  logic [DATA_W-1:0] mem_b [256];
  int                tests = 0;
  int                fails = 0;

  matmul_bt_operand_streamer_if #(.DATA_W(DATA_W), .DIM_W(DIM_W)) sif ();

  matmul_bt_operand_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .dim_m_i     (dim_m),
    .dim_n_i     (dim_n),
    .dim_k_i     (dim_k),
    .busy_o      (busy),
    .done_o      (done),
    .a_rd_en_o   (a_rd_en),
    .b_rd_en_o   (b_rd_en),
    .a_rd_addr_o (a_rd_addr),
    .b_rd_addr_o (b_rd_addr),
    .a_rd_data_i (a_rd_data),
    .b_rd_data_i (b_rd_data),
    .out_if      (sif)
  );

  always #5 clk = ~clk;

  // Synchronous-read operand memories: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr[7:0]];
    if (b_rd_en) b_rd_data <= mem_b[b_rd_addr[7:0]];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [31:0] a, input logic [31:0] b,
                                        input logic last, input logic [7:0] r, input logic [7:0] c);
    return {47'd0, a, b, last, r, c};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "/busy"},  128'(busy), '0);
    check({tag, "/done"},  128'(done), '0);
    check({tag, "/a_en"},  128'(a_rd_en), '0);
    check({tag, "/b_en"},  128'(b_rd_en), '0);
    check({tag, "/valid"}, 128'(sif.valid_out), '0);
    check({tag, "/a_adr"}, 128'(a_rd_addr), '0);
    check({tag, "/b_adr"}, 128'(b_rd_addr), '0);
    check({tag, "/beat"},
          pack(sif.data_a, sif.data_b, sif.last_k, sif.out_row, sif.out_col), '0);
  endtask

  task automatic run_job(input int m, input int n, input int k, input bit rnd_ready,
                         input int fill, input int poke_cyc, input int abort_beats);
    logic [127:0] exp_beats[$];
    logic [127:0] got_beats[$];
    int           exp_a[$], exp_b[$], got_a[$], got_b[$];
    int           cyc, done_cyc, done_cnt, first_valid, issued, xfers, n_valid;
    bit           done_seen, stall_prev;
    logic         busy_c1;
    logic [127:0] cur_beat, prev_beat;
    string        tag;

    tag = $sformatf("job%0dx%0dx%0d", m, n, k);
    for (int x = 0; x < 256; x++) begin
      case (fill)
        1: begin mem_a[x] = 32'(x); mem_b[x] = 32'(x); end
        2: begin
          mem_a[x] = (x == 0) ? 32'h11 : $urandom;
          mem_b[x] = (x == 0) ? 32'h22 : $urandom;
        end
        default: begin mem_a[x] = $urandom; mem_b[x] = $urandom; end
      endcase
    end

    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int kk = 0; kk < k; kk++) begin
          exp_a.push_back(i * k + kk);
          exp_b.push_back(j * k + kk);
          exp_beats.push_back(pack(mem_a[i * k + kk], mem_b[j * k + kk], kk == k - 1, 8'(i), 8'(j)));
        end

    @(posedge clk);
    #1;
    dim_m = 8'(m);
    dim_n = 8'(n);
    dim_k = 8'(k);
    start = 1'b1;
    sif.ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0; done_cyc = -1; done_cnt = 0; first_valid = -1;
    issued = 0; xfers = 0; n_valid = 0;
    done_seen = 1'b0; stall_prev = 1'b0; busy_c1 = 1'b0; prev_beat = '0;

    forever begin
      @(negedge clk);
      cur_beat = pack(sif.data_a, sif.data_b, sif.last_k, sif.out_row, sif.out_col);
      check($sformatf("%s/rd_en_pair@%0d", tag, cyc), 128'(a_rd_en), 128'(b_rd_en));
      if (a_rd_en) begin
        got_a.push_back(int'(a_rd_addr));
        got_b.push_back(int'(b_rd_addr));
        issued++;
      end
      check($sformatf("%s/inflight@%0d", tag, cyc), 128'(issued - xfers <= 2), 128'(1));
      if (stall_prev) begin
        check($sformatf("%s/hold_valid@%0d", tag, cyc), 128'(sif.valid_out), 128'(1));
        check($sformatf("%s/hold_beat@%0d", tag, cyc), cur_beat, prev_beat);
      end
      if (cyc == 1) busy_c1 = busy;
      if (sif.valid_out) begin
        n_valid++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (sif.valid_out && sif.ready_in) begin
        got_beats.push_back(cur_beat);
        xfers++;
      end
      stall_prev = sif.valid_out && !sif.ready_in;
      prev_beat  = cur_beat;
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_seen = 1'b1;
      end
      if (done_seen || cyc >= BUDGET) break;
      if (abort_beats > 0 && xfers == abort_beats) break;
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == poke_cyc);
      if (start) begin dim_m = 8'd1; dim_n = 8'd1; dim_k = 8'd1; end
      sif.ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    if (abort_beats > 0) begin
      check({tag, "/no_done_before_abort"}, 128'(done_cnt), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check_reset({tag, "/abort"});
      repeat (2) begin
        @(negedge clk);
        check({tag, "/abort_done"}, 128'(done), '0);
      end
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check({tag, "/post_abort_done"},  128'(done), '0);
        check({tag, "/post_abort_valid"}, 128'(sif.valid_out), '0);
        check({tag, "/post_abort_rd"},    128'(a_rd_en), '0);
      end
      $display("[TB] %s aborted by reset after %0d beats", tag, xfers);
      return;
    end

    check({tag, "/finished"}, 128'(done_seen), 128'(1));
    check({tag, "/busy_c1"}, 128'(busy_c1), 128'(1));
    check({tag, "/beat_count"}, 128'(got_beats.size()), 128'(exp_beats.size()));
    for (int b = 0; b < got_beats.size() && b < exp_beats.size(); b++)
      check($sformatf("%s/beat%0d", tag, b), got_beats[b], exp_beats[b]);
    check({tag, "/read_count"}, 128'(got_a.size()), 128'(exp_a.size()));
    for (int r = 0; r < got_a.size() && r < exp_a.size(); r++) begin
      check($sformatf("%s/a_addr%0d", tag, r), 128'(got_a[r]), 128'(exp_a[r]));
      check($sformatf("%s/b_addr%0d", tag, r), 128'(got_b[r]), 128'(exp_b[r]));
    end
    if (m * n * k == 0) begin
      check({tag, "/zero_done_cyc"}, 128'(done_cyc), 128'(1));
      check({tag, "/zero_valid"},    128'(n_valid), '0);
    end else if (!rnd_ready) begin
      check({tag, "/done_cyc"},    128'(done_cyc), 128'(m * n * k + 2));
      check({tag, "/first_valid"}, 128'(first_valid), 128'(2));
    end

    repeat (3) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check({tag, "/extra_done"}, 128'(done), '0);
      check({tag, "/idle_busy"},  128'(busy), '0);
      check({tag, "/idle_valid"}, 128'(sif.valid_out), '0);
    end
    $display("[TB] %s ready=%s beats=%0d reads=%0d done@%0d", tag,
             rnd_ready ? "random" : "high", got_beats.size(), got_a.size(), done_cyc);
  endtask

  initial begin
    sif.ready_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_job(1, 1, 1, 1'b0, 2, -1, 0);
    run_job(2, 2, 3, 1'b0, 1, -1, 0);
    run_job(2, 2, 3, 1'b1, 1, -1, 0);
    run_job(4, 4, 0, 1'b0, 0, -1, 0);
    run_job(3, 0, 2, 1'b0, 0, -1, 0);
    run_job(2, 2, 3, 1'b0, 0, 4, 0);
    run_job(2, 2, 3, 1'b1, 0, 6, 0);
    run_job(2, 2, 3, 1'b0, 1, -1, 5);
    run_job(2, 2, 3, 1'b0, 1, -1, 0);
    for (int r = 0; r < 4; r++)
      run_job($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), 1'b1, 0, -1, 0);
    run_job(3, 4, 2, 1'b0, 0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
